serializer_8b10b: RTL

- Transmit-side counterpart of the 8b/10b deserializer.
- Accepts bytes over a valid/ready handshake, encodes each with standard 8b/10b tables while tracking running disparity (RD), and shifts the 10-bit code word out one bit at a time.
- Sits between the byte source and the serial link into the async FIFO / deserializer path.

---
 rtl/serdes_8b10b_pkg.sv | 16 +
 rtl/encoder_8b10b.sv | 102 ++++++++++
 rtl/serializer_8b10b.sv | 130 +++++++++++++
 3 files changed

// File: rtl/serdes_8b10b_pkg.sv
// Shared types and constants for the 8b/10b serial transmit path.
package serdes_8b10b_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    // Layout is abcdei_fghj with 'a' in bit 9; bit 0 ('j') leaves the wire first.
    typedef logic [9:0] code_word_t;

    localparam int         WORD_BITS = 10;
    localparam code_word_t K28_5_RDN = 10'b0011111010;
    localparam code_word_t K28_5_RDP = 10'b1100000101;

endpackage

// File: rtl/encoder_8b10b.sv
// Combinational 8b/10b encoder: data/K byte plus running disparity in, code word and new disparity out.
// k_sel supports K.28.y and K.23/27/29/30.7; other K values encode as the matching D code.
module encoder_8b10b (
    input  logic [7:0] data,
    input  logic       k_sel,
    input  logic       rd_in,
    output logic [9:0] code,
    output logic       rd_out
);

    logic [4:0] x;
    logic [2:0] y;
    logic       use_k28;
    logic [5:0] six_base;
    logic       six_unbal;
    logic       six_inv;
    logic [5:0] six;
    logic       rd_mid;
    logic       use_a7;
    logic [3:0] four_base;
    logic       four_unbal;
    logic       four_inv;
    logic [3:0] four;

    always_comb begin
        x        = data[4:0];
        y        = data[7:5];
        use_k28  = k_sel && (x == 5'd28);

        // RD- column of the 5b/6b table; the RD+ form is the complement where it differs.
        six_base = 6'b000000;
        case (x)
            5'd0:  six_base = 6'b100111;
            5'd1:  six_base = 6'b011101;
            5'd2:  six_base = 6'b101101;
            5'd3:  six_base = 6'b110001;
            5'd4:  six_base = 6'b110101;
            5'd5:  six_base = 6'b101001;
            5'd6:  six_base = 6'b011001;
            5'd7:  six_base = 6'b111000;
            5'd8:  six_base = 6'b111001;
            5'd9:  six_base = 6'b100101;
            5'd10: six_base = 6'b010101;
            5'd11: six_base = 6'b110100;
            5'd12: six_base = 6'b001101;
            5'd13: six_base = 6'b101100;
            5'd14: six_base = 6'b011100;
            5'd15: six_base = 6'b010111;
            5'd16: six_base = 6'b011011;
            5'd17: six_base = 6'b100011;
            5'd18: six_base = 6'b010011;
            5'd19: six_base = 6'b110010;
            5'd20: six_base = 6'b001011;
            5'd21: six_base = 6'b101010;
            5'd22: six_base = 6'b011010;
            5'd23: six_base = 6'b111010;
            5'd24: six_base = 6'b110011;
            5'd25: six_base = 6'b100110;
            5'd26: six_base = 6'b010110;
            5'd27: six_base = 6'b110110;
            5'd28: six_base = 6'b001110;
            5'd29: six_base = 6'b101110;
            5'd30: six_base = 6'b011110;
            5'd31: six_base = 6'b101011;
        endcase
        if (use_k28) begin
            six_base = 6'b001111;
        end

        six_unbal = ($countones(six_base) != 3);
        // D.7 is balanced but still has distinct RD-/RD+ forms.
        six_inv   = rd_in && (six_unbal || ((x == 5'd7) && !use_k28));
        six       = six_inv ? ~six_base : six_base;
        rd_mid    = rd_in ^ six_unbal;

        use_a7 = (y == 3'd7) &&
                 (k_sel ||
                  (!rd_mid && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20))) ||
                  ( rd_mid && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14))));

        four_base = 4'b0000;
        case (y)
            3'd0: four_base = 4'b1011;
            3'd1: four_base = 4'b1001;
            3'd2: four_base = 4'b0101;
            3'd3: four_base = 4'b1100;
            3'd4: four_base = 4'b1101;
            3'd5: four_base = 4'b1010;
            3'd6: four_base = 4'b0110;
            3'd7: four_base = use_a7 ? 4'b0111 : 4'b1110;
        endcase

        four_unbal = (y == 3'd0) || (y == 3'd4) || (y == 3'd7);
        // K codes flip the balanced 4b forms when the sub-block starts at RD-.
        four_inv   = (four_unbal || (y == 3'd3)) ? rd_mid : (k_sel && !rd_mid);
        four       = four_inv ? ~four_base : four_base;

        code   = {six, four};
        rd_out = rd_mid ^ four_unbal;
    end

endmodule

// File: rtl/serializer_8b10b.sv
// 8b/10b serial transmitter: accepts bytes on valid/ready, encodes with running disparity, shifts LSB first.
// Build macro SER_IDLE_COMMA_EN: K28.5 commas fill every word boundary that has no byte to send.
module serializer_8b10b
    import serdes_8b10b_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic [7:0] i_Data,
    input  logic       i_Valid,
    output logic       o_Ready,
    output logic       o_Serial,
    output logic       o_Tx_Active,
    output logic       o_Word_Done,
    output logic       o_Disparity
);

    localparam int               CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       BIT_LAST = 4'(WORD_BITS - 1);

    ser_state_t       state, state_n;
    code_word_t       shreg, shreg_n;
    logic [3:0]       bit_idx, bit_idx_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             rd, rd_n;
    logic             word_done, word_done_n;

    logic             bit_last;
    logic             boundary;
    logic             ready;
    logic             accept;
    logic             load_comma;
    logic             load;
    code_word_t       load_word;
    logic             load_rd;
    code_word_t       enc_code;
    logic             enc_rd;

    encoder_8b10b u_encoder (
        .data   (i_Data),
        .k_sel  (1'b0),
        .rd_in  (rd),
        .code   (enc_code),
        .rd_out (enc_rd)
    );

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_idx   <= '0;
            cnt       <= '0;
            rd        <= 1'b0;
            word_done <= 1'b0;
        end else begin
            state     <= state_n;
            shreg     <= shreg_n;
            bit_idx   <= bit_idx_n;
            cnt       <= cnt_n;
            rd        <= rd_n;
            word_done <= word_done_n;
        end
    end

    // Handshake: a byte transfers on a rising edge where i_Valid && o_Ready. o_Ready is high in IDLE
    // and in the last cycle of bit 9, never during reset; i_Data is ignored whenever o_Ready is low.
    always_comb begin
        bit_last = (state == SHIFT) && (bit_idx == BIT_LAST) && (cnt == CNT_LAST);
        boundary = (state == IDLE) || bit_last;
        ready    = !i_Rst && boundary;
        accept   = i_Valid && ready;
`ifdef SER_IDLE_COMMA_EN
        load_comma = ready && !i_Valid;
`else
        load_comma = 1'b0;
`endif
        load      = accept || load_comma;
        load_word = load_comma ? (rd ? K28_5_RDP : K28_5_RDN) : enc_code;
        load_rd   = load_comma ? ~rd : enc_rd;

        state_n     = state;
        shreg_n     = shreg;
        bit_idx_n   = bit_idx;
        cnt_n       = cnt;
        rd_n        = rd;
        word_done_n = 1'b0;

        case (state)
            IDLE: begin
                if (load) begin
                    state_n   = SHIFT;
                    shreg_n   = load_word;
                    bit_idx_n = '0;
                    cnt_n     = '0;
                    rd_n      = load_rd;
                end
            end
            SHIFT: begin
                if (cnt != CNT_LAST) begin
                    cnt_n = cnt + 1'b1;
                end else begin
                    cnt_n = '0;
                    if (bit_idx == BIT_LAST) begin
                        word_done_n = 1'b1;
                        if (load) begin
                            shreg_n   = load_word;
                            bit_idx_n = '0;
                            rd_n      = load_rd;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        bit_idx_n = bit_idx + 4'd1;
                        shreg_n   = {1'b0, shreg[9:1]};
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign o_Ready     = ready;
    assign o_Serial    = (state == SHIFT) && shreg[0];
    assign o_Tx_Active = (state == SHIFT);
    assign o_Word_Done = word_done;
    assign o_Disparity = rd;

endmodule
